// File: rtl/log_calculator.sv
// Mitchell log2 front end: leading-one characteristic plus left-aligned
// fraction, captured into output registers on in_valid.
module log_calculator (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic [2:0] w1,
  output logic [7:0] w2,
  output logic       zero,
  output logic       out_valid
);

  logic [2:0] k;
  logic [7:0] norm;
  logic [7:0] frac;
  logic       is_zero;

  logic [2:0] w1_q, w1_d;
  logic [7:0] w2_q, w2_d;
  logic       zero_q, zero_d;
  logic       vld_q, vld_d;

  // Higher bits overwrite lower ones, so bit 7 wins.
  always_comb begin
    k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (in[i]) k = 3'(i);
    end
  end

  // Leading one lands on bit 7 and is then shifted out.
  always_comb begin
    norm    = in << (3'd7 - k);
    frac    = {norm[6:0], 1'b0};
    is_zero = (in == 8'd0);
  end

  always_comb begin
    w1_d   = w1_q;
    w2_d   = w2_q;
    zero_d = zero_q;
    vld_d  = in_valid;
    if (in_valid) begin
      w1_d   = k;
      w2_d   = frac;
      zero_d = is_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w1_q   <= 3'd0;
      w2_q   <= 8'd0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      zero_q <= zero_d;
      vld_q  <= vld_d;
    end
  end

  assign w1        = w1_q;
  assign w2        = w2_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_log_calculator.sv
// Self-checking bench for log_calculator: directed cases, exhaustive
// sweep and random valid/hold stream against an arithmetic log2 model.
module tb_log_calculator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'd0;
  logic [2:0] w1;
  logic [7:0] w2;
  logic       zero;
  logic       out_valid;

  int n_vec = 0;
  int n_bad = 0;

  int m_k = 0;
  int m_f = 0;
  int m_z = 0;

  log_calculator dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in(in),
    .w1(w1),
    .w2(w2),
    .zero(zero),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // floor(log2(x)) and (x - 2^k) / 2^k scaled to 1/256 units
  task automatic model(input int x);
    int p;
    m_k = 0;
    p   = 1;
    while (p * 2 <= x) begin
      p   = p * 2;
      m_k = m_k + 1;
    end
    m_f = (x == 0) ? 0 : ((x - p) * 256) / p;
    m_z = (x == 0) ? 1 : 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int k, input int f,
                         input int z, input int v);
    chk({tag, ".w1"}, int'(w1), k);
    chk({tag, ".w2"}, int'(w2), f);
    chk({tag, ".zero"}, int'(zero), z);
    chk({tag, ".ov"}, int'(out_valid), v);
  endtask

  task automatic apply(input string tag, input int x);
    in_valid = 1'b1;
    in = 8'(x);
    cyc();
    model(x);
    chk_out(tag, m_k, m_f, m_z, 1);
  endtask

  int tk[6] = '{4, 4, 7, 6, 7, 7};
  int tf[6] = '{8'h70, 8'h80, 8'h64, 8'h78, 8'h00, 8'hFE};
  int tx[6] = '{8'h17, 8'h18, 8'hB2, 8'h5E, 8'h80, 8'hFF};
  int sk[16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
  int sf[16] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h40, 8'h80, 8'hC0,
                 8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0};

  initial begin
    int hk, hf, hz;
    rst = 1'b1;
    cyc();
    chk_out("por", 0, 0, 0, 0);
    rst = 1'b0;

    // load something nonzero, then reset with no clock edge
    apply("pre", 8'h5E);
    rst = 1'b1;
    in_valid = 1'b1;
    in = 8'hFF;
    #1;
    chk_out("arst", 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    cyc();
    chk_out("rel", 7, 8'hFE, 0, 1);

    // small values against literal table
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in = 8'(i);
      cyc();
      chk_out($sformatf("small%0d", i), sk[i], sf[i], (i == 0) ? 1 : 0, 1);
    end

    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in = 8'(tx[i]);
      cyc();
      chk_out($sformatf("mid%0h", tx[i]), tk[i], tf[i], 0, 1);
    end

    // hold
    apply("ldB2", 8'hB2);
    in_valid = 1'b0;
    in = 8'h03;
    cyc();
    chk_out("hold", 7, 8'h64, 0, 0);

    // mid-stream reset
    apply("s5E", 8'h5E);
    in_valid = 1'b1;
    in = 8'h17;
    #2;
    rst = 1'b1;
    #1;
    chk_out("midrst", 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    cyc();
    chk_out("post", 4, 8'h70, 0, 1);

    // exhaustive back-to-back
    for (int i = 0; i < 256; i++)
      apply($sformatf("ex%0h", i), i);

    // random valid/hold stream
    model(255);
    hk = m_k; hf = m_f; hz = m_z;
    for (int i = 0; i < 400; i++) begin
      int v, x;
      v = int'($urandom_range(0, 1));
      x = int'($urandom_range(0, 255));
      in_valid = v[0];
      in = 8'(x);
      cyc();
      if (v == 1) begin
        model(x);
        hk = m_k; hf = m_f; hz = m_z;
      end
      chk_out($sformatf("rnd%0d", i), hk, hf, hz, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
